// File: rtl/mc14433_pkg.sv
// Shared types and constants for the MC14433 DVM readout: FSM encoding,
// digit-strobe indices and reading widths.
package mc14433_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_DS1,
    W_DS2,
    W_DS3,
    W_DS4,
    CONV
  } state_t;

  localparam int DS1_IDX   = 0;
  localparam int DS2_IDX   = 1;
  localparam int DS3_IDX   = 2;
  localparam int DS4_IDX   = 3;
  localparam int READING_W = 12;
  localparam int MAG_W     = 11;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // One-hot strobe that a waiting state is allowed to accept.
  function automatic logic [3:0] expected_strobe(input state_t s);
    logic [3:0] m;
    m = 4'b0000;
    case (s)
      W_DS1:   m[DS1_IDX] = 1'b1;
      W_DS2:   m[DS2_IDX] = 1'b1;
      W_DS3:   m[DS3_IDX] = 1'b1;
      W_DS4:   m[DS4_IDX] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic state_t next_wait(input state_t s);
    state_t n;
    case (s)
      W_DS1:   n = W_DS2;
      W_DS2:   n = W_DS3;
      W_DS3:   n = W_DS4;
      W_DS4:   n = CONV;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mc14433_readout_bcd4_to_bin.sv
// Converts the half digit plus three BCD digits of a frame into an 11-bit
// binary magnitude (0..1999) and flags any digit outside 0..9.
import mc14433_pkg::*;

module bcd4_to_bin (
  input  logic             half,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  input  logic [3:0]       d4,
  output logic [MAG_W-1:0] mag,
  output logic             dig_err
);

  assign mag = (half ? MAG_W'(1000) : MAG_W'(0))
             + MAG_W'(d2) * MAG_W'(100)
             + MAG_W'(d3) * MAG_W'(10)
             + MAG_W'(d4);

  assign dig_err = !bcd_ok(d2) || !bcd_ok(d3) || !bcd_ok(d4);

endmodule

// File: rtl/mc14433_readout.sv
// Captures one multiplexed MC14433 conversion frame (EOC, DS1..DS4) and
// presents it as a signed reading with a valid/ready handshake.
import mc14433_pkg::*;

module mc14433_readout #(
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 EOC,
  input  logic [3:0]           DS,
  input  logic [3:0]           Q,
  input  logic                 rdy,
  output logic                 vld,
  output logic [READING_W-1:0] reading,
  output logic                 ovr_rng,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state, state_nxt;
  logic                 eoc_q;
  logic [3:0]           ds_q;
  logic                 eoc_edge;
  logic [3:0]           ds_edge;
  logic                 waiting, ds_hit, strobe_ok, digit_ok, timed_out;
  logic                 capture, frame_abort, conv_done;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 half_q, pos_q, rng_q;
  logic [3:0]           d2_q, d3_q, d4_q;
  logic [MAG_W-1:0]     mag;
  logic                 dig_err;
  logic [READING_W-1:0] mag_ext, signed_val;

  assign eoc_edge  = EOC & ~eoc_q;
  assign ds_edge   = DS & ~ds_q;
  assign waiting   = state inside {W_DS1, W_DS2, W_DS3, W_DS4};
  assign ds_hit    = |ds_edge;
  // Exact match against a one-hot mask also rejects simultaneous strobes.
  assign strobe_ok = (ds_edge == expected_strobe(state));
  assign digit_ok  = (state == W_DS1) || bcd_ok(Q);
  assign timed_out = (tmo_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (R) begin
      eoc_q <= 1'b0;
      ds_q  <= 4'b0000;
    end else begin
      eoc_q <= EOC;
      ds_q  <= DS;
    end
  end

  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (eoc_edge) state_nxt = W_DS1;
      W_DS1, W_DS2, W_DS3, W_DS4: begin
        if (eoc_edge)       state_nxt = W_DS1;
        else if (ds_hit)    state_nxt = (strobe_ok && digit_ok) ? next_wait(state) : IDLE;
        else if (timed_out) state_nxt = IDLE;
      end
      CONV:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture     = 1'b0;
    frame_abort = 1'b0;
    conv_done   = 1'b0;
    case (state)
      W_DS1, W_DS2, W_DS3, W_DS4: begin
        if (eoc_edge) begin
          frame_abort = 1'b1;
        end else if (ds_hit) begin
          if (strobe_ok && digit_ok) capture     = 1'b1;
          else                       frame_abort = 1'b1;
        end else if (timed_out) begin
          frame_abort = 1'b1;
        end
      end
      CONV: begin
        conv_done   = ~dig_err;
        frame_abort = dig_err;
      end
      default: ;
    endcase
  end

  // Gap counter between frame events; idle states hold it at zero.
  always_ff @(posedge clk) begin
    if (R || !waiting || eoc_edge || capture) tmo_cnt <= '0;
    else if (!timed_out)                      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      half_q <= 1'b0;
      pos_q  <= 1'b0;
      rng_q  <= 1'b0;
      d2_q   <= 4'd0;
      d3_q   <= 4'd0;
      d4_q   <= 4'd0;
    end else if (capture) begin
      case (state)
        W_DS1: begin
          half_q <= ~Q[3];
          pos_q  <= Q[2];
          rng_q  <= Q[0];
        end
        W_DS2:   d2_q <= Q;
        W_DS3:   d3_q <= Q;
        W_DS4:   d4_q <= Q;
        default: ;
      endcase
    end
  end

  bcd4_to_bin u_bcd (
    .half    (half_q),
    .d2      (d2_q),
    .d3      (d3_q),
    .d4      (d4_q),
    .mag     (mag),
    .dig_err (dig_err)
  );

  assign mag_ext    = READING_W'(mag);
  assign signed_val = pos_q ? mag_ext : -mag_ext;

  // A new reading always wins; overrun records that the old one was never taken.
  always_ff @(posedge clk) begin
    if (R) begin
      vld       <= 1'b0;
      reading   <= '0;
      ovr_rng   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_abort;
      if (conv_done) begin
        reading <= signed_val;
        ovr_rng <= rng_q;
        vld     <= 1'b1;
        if (vld && !rdy) overrun <= 1'b1;
      end else if (vld && rdy) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc14433_readout.sv
// Randomized frame-level bench for mc14433_readout with a reading/handshake
// reference model built from the decoding rules.
module tb_mc14433_readout;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        R, EOC, rdy;
  logic [3:0]  DS, Q;
  logic        vld, ovr_rng, frame_err, overrun;
  logic [11:0] reading;

  int checks = 0;
  int errors = 0;
  int fe_count = 0;
  int exp_fe = 0;
  int gap_max = 4;

  logic        m_vld, m_rng, m_overrun;
  logic [11:0] m_reading;

  mc14433_readout #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .R         (R),
    .EOC       (EOC),
    .DS        (DS),
    .Q         (Q),
    .rdy       (rdy),
    .vld       (vld),
    .reading   (reading),
    .ovr_rng   (ovr_rng),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_count++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic eoc, input logic [3:0] ds, input logic [3:0] q);
    @(posedge clk);
    #1;
    EOC = eoc;
    DS  = ds;
    Q   = q;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'b0000, 4'($urandom));
  endtask

  task automatic gap();
    idle($urandom_range(0, gap_max));
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_vld"}, vld, m_vld);
    checkOutput({tag, "_reading"}, reading, m_reading);
    checkOutput({tag, "_ovr_rng"}, ovr_rng, m_rng);
    checkOutput({tag, "_overrun"}, overrun, m_overrun);
    checkOutput({tag, "_frame_err_count"}, fe_count, exp_fe);
  endtask

  task automatic do_reset(input string tag);
    R = 1'b1;
    idle(2);
    sample();
    checkOutput({tag, "_vld"}, vld, 1'b0);
    checkOutput({tag, "_reading"}, reading, 12'h000);
    checkOutput({tag, "_ovr_rng"}, ovr_rng, 1'b0);
    checkOutput({tag, "_overrun"}, overrun, 1'b0);
    checkOutput({tag, "_frame_err"}, frame_err, 1'b0);
    R = 1'b0;
    m_vld = 1'b0; m_rng = 1'b0; m_overrun = 1'b0; m_reading = 12'h000;
  endtask

  // kind: 0 good, 1 wrong strobe order, 2 two strobes at once, 3 EOC restart
  // then good, 4 bad BCD digit (first of d2..d4 above 9), 5 timeout after DS1.
  // mode: 0 rdy low, 1 rdy high, 2 rdy high only in the completion cycle.
  task automatic run_frame(input string tag, input int kind, input int mode,
                           input bit half, input bit pos, input bit rng,
                           input int d2, input int d3, input int d4);
    logic [3:0]  q1;
    logic [11:0] exp_rd;
    int          mag;
    q1     = {~half, pos, 1'($urandom), rng};
    mag    = (half ? 1000 : 0) + d2 * 100 + d3 * 10 + d4;
    exp_rd = pos ? 12'(mag) : 12'(-mag);
    rdy    = (mode == 1);
    if (mode == 1) m_vld = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'($urandom));
    gap();
    case (kind)
      1: begin
        applyStimulus(1'b0, 4'b0001, q1); gap();
        applyStimulus(1'b0, 4'b0100, 4'($urandom_range(0, 9))); gap();
        applyStimulus(1'b0, 4'b1000, 4'($urandom_range(0, 9)));
        exp_fe++;
      end
      2: begin
        applyStimulus(1'b0, 4'b0001, q1); gap();
        applyStimulus(1'b0, 4'b0110, 4'($urandom_range(0, 9)));
        exp_fe++;
      end
      4: begin
        applyStimulus(1'b0, 4'b0001, q1); gap();
        applyStimulus(1'b0, 4'b0010, 4'(d2));
        if (d2 <= 9) begin
          gap();
          applyStimulus(1'b0, 4'b0100, 4'(d3));
          if (d3 <= 9) begin
            gap();
            applyStimulus(1'b0, 4'b1000, 4'(d4));
          end
        end
        exp_fe++;
      end
      5: begin
        applyStimulus(1'b0, 4'b0001, q1);
        idle(2 * TMO);
        exp_fe++;
        applyStimulus(1'b0, 4'b0100, 4'($urandom_range(0, 9))); gap();
        applyStimulus(1'b0, 4'b1000, 4'($urandom_range(0, 9))); gap();
        applyStimulus(1'b0, 4'b0001, q1);
      end
      default: ;
    endcase
    if (kind == 0 || kind == 3) begin
      if (kind == 3) begin
        applyStimulus(1'b0, 4'b0001, q1); gap();
        applyStimulus(1'b0, 4'b0010, 4'($urandom_range(0, 9))); gap();
        applyStimulus(1'b1, 4'b0000, 4'($urandom)); gap();
        exp_fe++;
      end
      applyStimulus(1'b0, 4'b0001, q1); gap();
      applyStimulus(1'b0, 4'b0010, 4'(d2)); gap();
      applyStimulus(1'b0, 4'b0100, 4'(d3)); gap();
      applyStimulus(1'b0, 4'b1000, 4'(d4));
      idle(1);
      if (mode == 2) rdy = 1'b1;
      sample();
      checkOutput({tag, "_pre_vld"}, vld, m_vld);
      checkOutput({tag, "_pre_reading"}, reading, m_reading);
      idle(1);
      if (mode == 2) rdy = 1'b0;
      if (mode == 0 && m_vld) m_overrun = 1'b1;
      m_vld = 1'b1; m_reading = exp_rd; m_rng = rng;
      sample();
      check_model(tag);
      idle(1);
      if (mode == 1) m_vld = 1'b0;
      sample();
      checkOutput({tag, "_post_vld"}, vld, m_vld);
    end else begin
      idle(3);
      sample();
      check_model(tag);
    end
  endtask

  initial begin
    R = 1'b1; EOC = 1'b0; DS = 4'b0000; Q = 4'b0000; rdy = 1'b0;
    do_reset("reset");

    run_frame("p1999", 0, 1, 1'b1, 1'b1, 1'b0, 9, 9, 9);
    checkOutput("p1999_value", reading, 12'h7CF);
    run_frame("m42", 0, 1, 1'b0, 1'b0, 1'b0, 0, 4, 2);
    checkOutput("m42_value", reading, 12'hFD6);
    run_frame("neg_zero", 0, 1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("neg_zero_value", reading, 12'h000);
    run_frame("held", 0, 0, 1'b1, 1'b0, 1'b0, 2, 3, 4);
    run_frame("order_err", 1, 0, 1'b0, 1'b1, 1'b0, 1, 1, 1);
    run_frame("after_err", 0, 1, 1'b0, 1'b1, 1'b0, 5, 6, 7);
    run_frame("ovr_a", 0, 0, 1'b1, 1'b1, 1'b1, 1, 2, 3);
    run_frame("ovr_b", 0, 0, 1'b0, 1'b0, 1'b0, 8, 7, 6);
    checkOutput("ovr_b_overrun", overrun, 1'b1);
    do_reset("ovr_reset");
    run_frame("timeout", 5, 0, 1'b1, 1'b1, 1'b0, 1, 1, 1);
    run_frame("bad_digit", 4, 0, 1'b1, 1'b1, 1'b0, 3, 12, 5);
    run_frame("hs_collide_a", 0, 0, 1'b0, 1'b1, 1'b0, 1, 0, 0);
    run_frame("hs_collide_b", 2, 2, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    gap_max = 12;
    run_frame("long_gaps", 0, 0, 1'b1, 1'b1, 1'b0, 4, 0, 4);
    gap_max = 4;

    rdy = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'h0); gap();
    applyStimulus(1'b0, 4'b0001, 4'b0100); gap();
    applyStimulus(1'b0, 4'b0010, 4'd3); gap();
    do_reset("mid_reset");
    applyStimulus(1'b0, 4'b0100, 4'd3); gap();
    applyStimulus(1'b0, 4'b1000, 4'd3);
    idle(4);
    sample();
    check_model("mid_reset_after");
    run_frame("post_reset", 0, 1, 1'b1, 1'b1, 1'b0, 3, 3, 3);

    for (int i = 0; i < 80; i++) begin
      int  kind, mode, d2, d3, d4, bad;
      kind = $urandom_range(0, 5);
      d2 = $urandom_range(0, 9); d3 = $urandom_range(0, 9); d4 = $urandom_range(0, 9);
      if (kind == 4) begin
        bad = $urandom_range(0, 2);
        if (bad == 0)      d2 = $urandom_range(10, 15);
        else if (bad == 1) d3 = $urandom_range(10, 15);
        else               d4 = $urandom_range(10, 15);
      end
      mode = (kind == 0 || kind == 3) ? $urandom_range(0, 2) : $urandom_range(0, 1);
      run_frame($sformatf("rnd%0d_k%0d", i, kind), kind, mode,
                1'($urandom), 1'($urandom), 1'($urandom), d2, d3, d4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc14433_readout.md
MC14433_READOUT -- requirements
Module: mc14433_readout

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, meaning the maximum clk cycles allowed between consecutive frame events (EOC to DS1, DSn to DSn+1).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port R  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port EOC  input  1  converter end-of-conversion, synchronous to clk.
REQ-005 SHALL have port DS  input  4  digit strobes; DS[0]=DS1 (MSD) through DS[3]=DS4 (LSD).
REQ-006 SHALL have port Q  input  4  multiplexed BCD/status bus.
REQ-007 SHALL have port rdy  input  1  downstream ready.
REQ-008 SHALL have port vld  output  1  reading valid.
REQ-009 SHALL have port reading  output  12  signed two's-complement reading, range -1999..+1999.
REQ-010 SHALL have port ovr_rng  output  1  over/under-range flag of the held reading.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-012 SHALL have port overrun  output  1  sticky flag: an unconsumed reading was overwritten.

Function
REQ-013 SHALL register EOC and DS each cycle; an edge SHALL be detected when the current input is 1 and the registered copy is 0.
REQ-014 SHALL use FSM states IDLE, W_DS1, W_DS2, W_DS3, W_DS4, CONV.
REQ-015 IDLE -> W_DS1 on an EOC edge; DS edges in IDLE SHALL be ignored.
REQ-016 In W_DSn, a DSn edge SHALL capture Q in that same cycle and advance to the next state; W_DS4 SHALL advance to CONV.
REQ-017 DS1 capture: Q[3]=0 means half-digit 1, Q[3]=1 means half-digit 0; Q[2]=1 means positive; Q[0]=1 sets the range flag.
REQ-018 DS2..DS4 captures SHALL be BCD hundreds, tens and units; a value >9 SHALL abort the frame.
REQ-019 CONV SHALL compute mag = half*1000 + d2*100 + d3*10 + d4 (11 bits, 0..1999), negate it when polarity is negative, and return to IDLE; -0 SHALL yield 0.
REQ-020 reading, ovr_rng and vld=1 SHALL update on the clk edge that ends CONV, i.e. 2 cycles after the cycle in which the DS4 edge is sampled.
REQ-021 vld SHALL stay high with reading stable until a cycle with vld=1 and rdy=1; vld SHALL drop on the following edge.
REQ-022 If CONV completes while vld=1 and rdy=0, the new reading SHALL overwrite, vld SHALL stay 1, and overrun SHALL set.
REQ-023 If CONV completes in the same cycle as a vld=1/rdy=1 handshake, the new reading SHALL load with vld=1 and overrun SHALL stay unchanged.
REQ-024 Abort conditions SHALL be: a DS edge other than the expected one; more than one DS edge in a cycle; an invalid BCD digit; or the timeout counter reaching TIMEOUT in any W_ state.
REQ-025 On abort, frame_err SHALL pulse for one cycle, captured data SHALL be discarded, and the FSM SHALL go to IDLE; the held reading and vld SHALL be unaffected.
REQ-026 An EOC edge in any W_ state SHALL pulse frame_err and restart at W_DS1.
REQ-027 The timeout counter SHALL clear on every accepted edge and saturate at TIMEOUT.
REQ-028 overrun SHALL clear only on R.

Reset
REQ-029 R=1 SHALL force: FSM=IDLE, vld=0, reading=0, ovr_rng=0, frame_err=0, overrun=0, edge registers=0, and counter=0, including mid-frame.
REQ-030 The first EOC edge after reset is detected only once R is low and the registered EOC copy is 0.

Structure
REQ-031 The FSM state encoding, the DS index constants and the 12-bit reading width SHALL reside in shared package mc14433_pkg.
REQ-032 BCD-to-binary conversion SHALL be one sub-module, bcd4_to_bin: half plus three digits in, 11-bit magnitude and a digit-error output.

Verification
REQ-033 Frame EOC, then DS1..DS4 with Q=4'b0100 (half=1, positive, no range), 9, 9, 9, and rdy=1 -> vld for 1 cycle, reading=+1999, ovr_rng=0.
REQ-034 DS1 Q=4'b1000 (half=0, negative), digits 0, 4, 2 -> reading=-42 (12'hFD6).
REQ-035 DS1, DS3 order after EOC -> frame_err pulse; vld unchanged; next good frame decodes correctly.
REQ-036 Two frames with rdy=0 throughout -> second reading held, vld=1, overrun=1; R -> all outputs 0.
REQ-037 With TIMEOUT=16 and no DS2 for 16 cycles -> frame_err pulse, FSM=IDLE; DS3 digit 4'hC in another frame -> frame_err.
REQ-038 R asserted between DS2 and DS3 -> all outputs 0, no vld; the following frame decodes correctly.
